// File: rtl/ptr_noc_pkg.sv
// ptr_noc_pkg: shared PtRing NoC definitions (network interface and router).
//   tx_state_e     : local NI transmit FSM states
//   STARVE_MAX     : loss count after which the loopback source wins the rx slot
//   ptr_ring_dist(): absolute destination ID -> ring hop count
package ptr_noc_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_RING = 2'd1,
    TX_LOOP = 2'd2
  } tx_state_e;

  localparam logic [1:0] STARVE_MAX = 2'd3;

  // Hops from self to dest going around the ring; 0 means self.
  // Only meaningful for dest < num.
  function automatic int ptr_ring_dist(input int dest, input int self, input int num);
    int sum;
    sum = dest + (num - self);
    if (sum >= num) sum = sum - num;
    return sum;
  endfunction

endpackage

// File: rtl/ptr_ni_rx_slot.sv
// ptr_ni_rx_slot: single-entry receive register between the local NI's
// source arbiter and the client valid/ready sink.
//   clk, rst   : clock, async active-high reset (entry discarded)
//   i_load     : write i_dat into the slot this cycle
//   i_dat      : data to load
//   i_rdy      : client ready
//   o_vld/o_dat: slot contents toward the client
//   o_canLoad  : slot can accept a load this cycle (empty, or draining now)
module ptr_ni_rx_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_dat,
  input  logic                  i_rdy,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_dat,
  output logic                  o_canLoad
);

  logic                  r_vld;
  logic [DATA_WIDTH-1:0] r_dat;

  assign o_canLoad = !r_vld | i_rdy;
  assign o_vld     = r_vld;
  assign o_dat     = r_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (i_load) begin
      r_vld <= 1'b1;
      r_dat <= i_dat;
    end else if (r_vld & i_rdy) begin
      r_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/ptr_local_ni.sv
// ptr_local_ni: local-node network interface of the PtRing NoC.
// Converts client packets addressed by absolute node ID into ring hop counts
// and writes them into the router's l2r FIFO; drains the router's r2l FIFO
// toward the client. Self-addressed packets loop back without entering the
// ring; illegal IDs are dropped and flagged on the sticky oErr.
//   clk, rst                   : clock, async active-high reset
//   iTxVld/oTxRdy/iTxDest/iTxDat : client transmit handshake
//   oL2rWr/iL2rFul/oL2rDat/oDestCnt : router l2r write port
//   iR2lPktVld/oR2lRd/iR2lDat  : router r2l FIFO (first-word fall-through)
//   oRxVld/iRxRdy/oRxDat       : client receive handshake
//   oErr                       : sticky illegal-destination flag
//   oTxCnt/oRxCnt              : packet counters, built only with
//                                `define PTR_NI_STATS_EN, otherwise tied to 0
module ptr_local_ni
  import ptr_noc_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NODE_NUM   = 8,
  parameter  int NODE_ID    = 0,
  localparam int CNT_W      = $clog2(NODE_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iTxVld,
  output logic                  oTxRdy,
  input  logic [CNT_W-1:0]      iTxDest,
  input  logic [DATA_WIDTH-1:0] iTxDat,
  output logic                  oL2rWr,
  input  logic                  iL2rFul,
  output logic [DATA_WIDTH-1:0] oL2rDat,
  output logic [CNT_W-1:0]      oDestCnt,
  input  logic                  iR2lPktVld,
  output logic                  oR2lRd,
  input  logic [DATA_WIDTH-1:0] iR2lDat,
  output logic                  oRxVld,
  input  logic                  iRxRdy,
  output logic [DATA_WIDTH-1:0] oRxDat,
  output logic                  oErr,
  output logic [15:0]           oTxCnt,
  output logic [15:0]           oRxCnt
);

  localparam int             DW1   = CNT_W + 1;
  localparam logic [CNT_W:0] L_NUM = DW1'(NODE_NUM);

  tx_state_e             r_state, w_next;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [CNT_W-1:0]      r_destCnt;
  logic                  r_err;
  logic [1:0]            r_starve;

  logic [CNT_W:0]        w_dist;
  logic                  w_legal;
  logic                  w_txRdy, w_l2rWr, w_accept;
  logic                  w_loopReq, w_loopWin, w_loopGnt;
  logic                  w_r2lRd, w_canLoad, w_load;
  logic [DATA_WIDTH-1:0] w_loadDat;

  // ---------------- destination decode ----------------
  assign w_legal = ({1'b0, iTxDest} < L_NUM);
  assign w_dist  = DW1'(ptr_ring_dist(int'(iTxDest), NODE_ID, NODE_NUM));

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= TX_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_txRdy  = 1'b0;
    w_l2rWr  = 1'b0;
    w_accept = 1'b0;
    unique case (r_state)
      TX_IDLE: w_txRdy = 1'b1;
      TX_RING: begin
        // The write firing frees the holding register, so a new packet can be
        // taken in the same cycle without a bubble.
        w_l2rWr = !iL2rFul;
        w_txRdy = !iL2rFul;
        if (!iL2rFul) w_next = TX_IDLE;
      end
      TX_LOOP: if (w_loopGnt) w_next = TX_IDLE;
      default: w_next = TX_IDLE;
    endcase
    w_accept = iTxVld & w_txRdy;
    if (w_accept) begin
      if (!w_legal)          w_next = TX_IDLE;
      else if (w_dist == '0) w_next = TX_LOOP;
      else                   w_next = TX_RING;
    end
  end

  // Holding register only changes on accept, so data/destCnt stay stable
  // while the ring write is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dat     <= '0;
      r_destCnt <= '0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      if (w_legal) begin
        r_dat     <= iTxDat;
        r_destCnt <= w_dist[CNT_W-1:0];
      end else begin
        r_err     <= 1'b1;
      end
    end
  end

  // ---------------- RX arbitration ----------------
  // Ring traffic wins by default; the loopback packet wins once it has lost
  // STARVE_MAX load slots in a row.
  assign w_loopReq = (r_state == TX_LOOP);
  assign w_loopWin = w_loopReq & (r_starve == STARVE_MAX);
  assign w_r2lRd   = iR2lPktVld & w_canLoad & !w_loopWin;
  assign w_loopGnt = w_loopReq & w_canLoad & !w_r2lRd;
  assign w_load    = w_r2lRd | w_loopGnt;
  assign w_loadDat = w_loopGnt ? r_dat : iR2lDat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_starve <= '0;
    else if (w_loopGnt)             r_starve <= '0;
    else if (w_loopReq & w_r2lRd)   r_starve <= r_starve + 2'd1;
  end

  ptr_ni_rx_slot #(.DATA_WIDTH(DATA_WIDTH)) u_rx_slot (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_dat     (w_loadDat),
    .i_rdy     (iRxRdy),
    .o_vld     (oRxVld),
    .o_dat     (oRxDat),
    .o_canLoad (w_canLoad)
  );

  // ---------------- outputs ----------------
  // Combinational strobes are forced low while reset is asserted so nothing
  // is written or popped in the reset cycle.
  assign oTxRdy   = w_txRdy & !rst;
  assign oL2rWr   = w_l2rWr & !rst;
  assign oR2lRd   = w_r2lRd & !rst;
  assign oL2rDat  = r_dat;
  assign oDestCnt = r_destCnt;
  assign oErr     = r_err;

`ifdef PTR_NI_STATS_EN
  logic [15:0] r_txCnt, r_rxCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txCnt <= '0;
      r_rxCnt <= '0;
    end else begin
      if (w_l2rWr)          r_txCnt <= r_txCnt + 16'd1;
      if (oRxVld & iRxRdy)  r_rxCnt <= r_rxCnt + 16'd1;
    end
  end

  assign oTxCnt = r_txCnt;
  assign oRxCnt = r_rxCnt;
`else
  assign oTxCnt = '0;
  assign oRxCnt = '0;
`endif

endmodule

// File: doc/ptr_local_ni.md
Name: ptr_local_ni

Overview:
- Local-node network interface for the PtRing NoC. It is the node-side endpoint of the router's local port.
- Accepts client packets addressed by absolute node ID and converts each ID to a ring hop count (destCnt). Drives the router's l2r write port and drains the router's r2l FIFO toward a client valid/ready sink.
- Self-addressed packets loop back internally and never enter the ring.
- One instance per ring node.

Parameters:
- DATA_WIDTH, 32, payload width; must equal the router's DATA_WIDTH.
- NODE_NUM, 8, number of nodes on the ring.
- NODE_ID, 0, this node's absolute ID, 0..NODE_NUM-1.
- CNT_W, $clog2(NODE_NUM), localparam; width of destCnt and node IDs.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- iTxVld  in  1  client packet valid.
- oTxRdy  out  1  client packet accepted when iTxVld & oTxRdy.
- iTxDest  in  CNT_W  absolute destination node ID.
- iTxDat  in  DATA_WIDTH  client payload.
- oL2rWr  out  1  write strobe to router l2r FIFO.
- iL2rFul  in  1  router l2r FIFO full.
- oL2rDat  out  DATA_WIDTH  payload to router.
- oDestCnt  out  CNT_W  ring hop count to router.
- iR2lPktVld  in  1  router r2l FIFO not empty (first-word fall-through).
- oR2lRd  out  1  pop router r2l FIFO.
- iR2lDat  in  DATA_WIDTH  r2l head data, valid while iR2lPktVld.
- oRxVld  out  1  client receive valid.
- iRxRdy  in  1  client receive ready.
- oRxDat  out  DATA_WIDTH  received payload.
- oErr  out  1  sticky flag: an illegal destination was dropped.
- oTxCnt  out  16  packets sent on ring (PTR_NI_STATS_EN).
- oRxCnt  out  16  packets delivered to client (PTR_NI_STATS_EN).

Behaviour:
- Reset: every output is 0, TX FSM is in IDLE, rx register is empty, counters are 0.
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Hop count: dist = (iTxDest - NODE_ID + NODE_NUM) mod NODE_NUM.
  - Computed in CNT_W+1 bits and registered on accept.
  - dist 1 means the next router delivers the packet.
- Illegal destination: iTxDest >= NODE_NUM is accepted but dropped; oErr is set and stays set until rst. The FSM stays in IDLE.
- TX FSM has three states: IDLE, RING, LOOP.
  - IDLE: oTxRdy=1. On accept, go to LOOP if dist==0, to RING if dist!=0 and the destination is legal, otherwise stay in IDLE.
  - RING:
    - oL2rWr = !iL2rFul, combinational from the held data/destCnt.
    - oL2rDat and oDestCnt are held stable while the write is stalled.
    - When the write fires, return to IDLE. If iTxVld is high in the same cycle, accept the new packet in that cycle and go straight to its next state (zero-bubble back-to-back).
    - oTxRdy = !iL2rFul.
  - LOOP: oTxRdy=0. Deliver into the rx register when the arbiter grants it, then go to IDLE.
- RX register (1 entry):
  - Loads when it is empty, or when oRxVld & iRxRdy in the same cycle.
  - oRxVld/oRxDat come from the register; latency is 1 cycle from pop or loop grant.
- RX arbitration, each cycle the register can load:
  - The ring source wins by default: oR2lRd = iR2lPktVld & canLoad & !loopWin.
  - A 2-bit starvation counter increments each cycle LOOP loses. When it reaches 3, loopWin=1 and LOOP wins the next load.
  - The counter clears on the loop grant.
- Never write when full: oL2rWr is never asserted while iL2rFul=1.
- Never pop when empty: oR2lRd is never asserted while iR2lPktVld=0.
- Reset mid-operation: the held TX packet and the rx entry are discarded. No write or pop strobe is issued in the reset cycle.

Optional Feature:
- PTR_NI_STATS_EN defined:
  - oTxCnt increments on each fired oL2rWr.
  - oRxCnt increments on each oRxVld & iRxRdy.
  - Both are 16-bit and wrap 0xFFFF->0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package ptr_noc_pkg holds:
  - the TX FSM state enum;
  - the function ptr_ring_dist(dest, self, num);
  - the constant STARVE_MAX=3.
- The same package is intended to be shared by the router.
- One natural sub-module, ptr_ni_rx_slot: the 1-entry rx register with its load/valid/ready logic.

Test Plan (configuration NODE_NUM=6, NODE_ID=4, CNT_W=3):
- Ring wrap: send dest=1 with dat=0xA5, iL2rFul=0 -> next cycle oL2rWr=1, oDestCnt=3, oL2rDat=0xA5.
- Nearest neighbour and back-pressure: send dest=5 with iL2rFul=1 for 4 cycles -> oL2rWr=0 and oTxRdy=0 throughout, oDestCnt=1 held. Releasing iL2rFul gives a single oL2rWr pulse.
- Self-destined: send dest=4 with dat=0x3C -> oL2rWr never asserts; oRxVld=1 with oRxDat=0x3C within 2 cycles.
- Illegal destination: send dest=6 -> oErr=1 sticky, no oL2rWr, no oRxVld; a following dest=2 packet goes out with oDestCnt=4.
- Starvation: hold iR2lPktVld=1 and iRxRdy=1 while a dest=4 loop packet is pending -> the loop packet is delivered no later than the 4th load slot; no ring data is lost or duplicated (score by sequence numbers).
- Reset mid-operation: assert rst while RING is stalled and the rx register is full -> outputs go to 0 asynchronously. After release, oErr=0, oRxVld=0 and oTxRdy=1.
